hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset: i_clk  in  1  rising-edge clock; i_rst  in  1  asynchronous active-high reset.
REQ-002 SHALL have inputs i_id_rs1_addr (5) and i_id_rs2_addr (5): decode-stage source registers.
REQ-003 SHALL have inputs i_id_uses_rs1 (1) and i_id_uses_rs2 (1): the decode instruction reads that source.
REQ-004 SHALL have inputs i_ex_rd_addr (5), i_ex_reg_write (1) and i_ex_mem_read (1): ID/EX register outputs.
REQ-005 SHALL have inputs i_mem_rd_addr (5) and i_mem_reg_write (1): EX/MEM register outputs.
REQ-006 SHALL have input i_ex_redirect (1): branch taken or jump resolved in EX this cycle.
REQ-007 SHALL have input i_ex_retire_halt (1): a halt instruction is in EX.
REQ-008 SHALL have outputs o_pc_stall (1), o_if_id_stall (1), o_if_id_flush (1) and o_id_ex_flush (1); o_id_ex_flush drives the ID/EX bubble input.
REQ-009 SHALL have outputs o_halted (1), meaning the pipeline is drained and stopped, and o_stall_cnt (32), a count of bubble cycles.

Function
REQ-010 SHALL implement FSM states RUN, DRAIN and HALTED, with a 2-bit drain counter.
REQ-011 RUN, load-use: i_ex_mem_read=1, i_ex_rd_addr!=0, and i_ex_rd_addr equals a used ID source -> o_pc_stall=1, o_if_id_stall=1, o_id_ex_flush=1.
REQ-012 RUN, i_ex_redirect=1 -> o_if_id_flush=1, o_id_ex_flush=1, and no stall asserted; redirect SHALL override a same-cycle load-use stall.
REQ-013 RUN, i_ex_retire_halt=1 (and not squashed by a same-cycle redirect, which does not apply because the halt is in EX) -> go to DRAIN, load drain counter with 2, assert o_pc_stall=1 and o_if_id_flush=1.
REQ-014 DRAIN: o_pc_stall=1, o_if_id_flush=1, o_id_ex_flush=1 every cycle; decrement counter; at 0 go to HALTED next cycle.
REQ-015 HALTED: o_halted=1, o_pc_stall=1, both flushes=1; exit only via i_rst.
REQ-016 Hazard outputs SHALL be combinational from inputs plus state; there is zero cycle latency from hazard detect to stall.
REQ-017 o_stall_cnt SHALL increment by 1 on each clock edge where o_id_ex_flush=1 in RUN, and SHALL saturate at 32'hFFFFFFFF (no wrap).
REQ-018 Register x0 SHALL never cause a stall.
REQ-019 The register file writes through in WB, so WB writers SHALL never cause a stall.

Reset
REQ-020 i_rst SHALL asynchronously set state=RUN, drain counter=0, o_halted=0, o_stall_cnt=0.
REQ-021 While i_rst=1: o_pc_stall=0, o_if_id_stall=0, o_if_id_flush=1, o_id_ex_flush=1.
REQ-022 Reset asserted mid-DRAIN or in HALTED SHALL abort to RUN; the first post-reset edge behaves as RUN.

Configuration
REQ-023 Macro HAZARD_FORWARD_EN SHALL select the RAW policy.
REQ-024 With HAZARD_FORWARD_EN defined, the EX/MEM forwarding path exists, and the only RAW stall is load-use (REQ-011).
REQ-025 With HAZARD_FORWARD_EN undefined, RUN SHALL also stall (same outputs as REQ-011) when a used ID source matches a nonzero i_ex_rd_addr with i_ex_reg_write=1, or a nonzero i_mem_rd_addr with i_mem_reg_write=1.

Structure
REQ-026 The FSM state enum, drain length constant (2) and x0 address constant SHALL live in the shared pipeline package.
REQ-027 The block SHALL be a single module; the source-compare logic SHALL be one sub-module, hazard_cmp (addr, uses, rd, we -> match), instantiated per source/stage pair.

Verification
REQ-028 Forward on: EX lw x5, ID add x6,x5,x1 -> pc/if_id stall=1, id_ex_flush=1 for 1 cycle, o_stall_cnt 0->1.
REQ-029 Forward on: EX lw x0, ID uses x0 -> no stall, o_stall_cnt unchanged.
REQ-030 Redirect and load-use in the same cycle -> if_id_flush=1, id_ex_flush=1, pc_stall=0, if_id_stall=0.
REQ-031 Forward off: EX addi x7 (reg_write=1), ID uses x7 -> stall 1 cycle; then x7 in MEM -> stall a 2nd cycle; then x7 in WB -> no stall.
REQ-032 Halt in EX -> DRAIN for 3 edges, then o_halted=1 held; an i_rst pulse -> o_halted=0, state RUN.
REQ-033 Preload o_stall_cnt=32'hFFFFFFFE via forced stalls, then apply 3 stall cycles -> o_stall_cnt=32'hFFFFFFFF, held.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline constants for the hazard controller: FSM state encodings,
// drain length and the hard-wired zero register address.
package hazard_ctrl_pkg;

  typedef logic [1:0] hz_state_t;

  localparam hz_state_t StRun    = 2'd0;
  localparam hz_state_t StDrain  = 2'd1;
  localparam hz_state_t StHalted = 2'd2;

  // Drain counter load value; DRAIN lasts DrainLen + 1 clock edges.
  localparam logic [1:0] DrainLen = 2'd2;

  // x0 is hard-wired to zero and never produces a hazard.
  localparam logic [4:0] RegX0 = 5'd0;

endpackage

// File: rtl/hazard_cmp.sv
// Source/destination compare for one (ID source, producer stage) pair.
module hazard_cmp
  import hazard_ctrl_pkg::*;
(
  input  logic [4:0] i_addr,
  input  logic       i_uses,
  input  logic [4:0] i_rd,
  input  logic       i_we,
  output logic       o_match
);

  assign o_match = i_uses && i_we && (i_rd != RegX0) && (i_rd == i_addr);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use / RAW stalls, redirect flushes and a
// halt drain sequence. Define HAZARD_FORWARD_EN when the EX/MEM forwarding
// path exists; then only load-use stalls remain.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [4:0]  i_id_rs1_addr,
  input  logic [4:0]  i_id_rs2_addr,
  input  logic        i_id_uses_rs1,
  input  logic        i_id_uses_rs2,
  input  logic [4:0]  i_ex_rd_addr,
  input  logic        i_ex_reg_write,
  input  logic        i_ex_mem_read,
  input  logic [4:0]  i_mem_rd_addr,
  input  logic        i_mem_reg_write,
  input  logic        i_ex_redirect,
  input  logic        i_ex_retire_halt,
  output logic        o_pc_stall,
  output logic        o_if_id_stall,
  output logic        o_if_id_flush,
  output logic        o_id_ex_flush,
  output logic        o_halted,
  output logic [31:0] o_stall_cnt
);

  hz_state_t   state_q, state_d;
  logic [1:0]  drain_q, drain_d;
  logic [31:0] stall_cnt_q;
  logic        lu_rs1, lu_rs2;
  logic        raw_stall;

  hazard_cmp u_lu_rs1 (
    .i_addr (i_id_rs1_addr),
    .i_uses (i_id_uses_rs1),
    .i_rd   (i_ex_rd_addr),
    .i_we   (i_ex_mem_read),
    .o_match(lu_rs1)
  );

  hazard_cmp u_lu_rs2 (
    .i_addr (i_id_rs2_addr),
    .i_uses (i_id_uses_rs2),
    .i_rd   (i_ex_rd_addr),
    .i_we   (i_ex_mem_read),
    .o_match(lu_rs2)
  );

`ifdef HAZARD_FORWARD_EN
  assign raw_stall = lu_rs1 || lu_rs2;
`else
  logic ex_rs1, ex_rs2, mem_rs1, mem_rs2;

  hazard_cmp u_ex_rs1 (
    .i_addr (i_id_rs1_addr),
    .i_uses (i_id_uses_rs1),
    .i_rd   (i_ex_rd_addr),
    .i_we   (i_ex_reg_write),
    .o_match(ex_rs1)
  );

  hazard_cmp u_ex_rs2 (
    .i_addr (i_id_rs2_addr),
    .i_uses (i_id_uses_rs2),
    .i_rd   (i_ex_rd_addr),
    .i_we   (i_ex_reg_write),
    .o_match(ex_rs2)
  );

  hazard_cmp u_mem_rs1 (
    .i_addr (i_id_rs1_addr),
    .i_uses (i_id_uses_rs1),
    .i_rd   (i_mem_rd_addr),
    .i_we   (i_mem_reg_write),
    .o_match(mem_rs1)
  );

  hazard_cmp u_mem_rs2 (
    .i_addr (i_id_rs2_addr),
    .i_uses (i_id_uses_rs2),
    .i_rd   (i_mem_rd_addr),
    .i_we   (i_mem_reg_write),
    .o_match(mem_rs2)
  );

  assign raw_stall = lu_rs1 || lu_rs2 || ex_rs1 || ex_rs2 || mem_rs1 || mem_rs2;
`endif

  // Next state and zero-latency hazard outputs; reset forces a bubble.
  always_comb begin
    state_d       = state_q;
    drain_d       = drain_q;
    o_pc_stall    = 1'b0;
    o_if_id_stall = 1'b0;
    o_if_id_flush = 1'b0;
    o_id_ex_flush = 1'b0;
    case (state_q)
      StRun: begin
        if (i_ex_retire_halt) begin
          state_d       = StDrain;
          drain_d       = DrainLen;
          o_pc_stall    = 1'b1;
          o_if_id_flush = 1'b1;
        end else if (i_ex_redirect) begin
          // Redirect squashes the stalled ID instruction anyway.
          o_if_id_flush = 1'b1;
          o_id_ex_flush = 1'b1;
        end else if (raw_stall) begin
          o_pc_stall    = 1'b1;
          o_if_id_stall = 1'b1;
          o_id_ex_flush = 1'b1;
        end
      end
      StDrain: begin
        o_pc_stall    = 1'b1;
        o_if_id_flush = 1'b1;
        o_id_ex_flush = 1'b1;
        if (drain_q == 2'd0) begin
          state_d = StHalted;
        end else begin
          drain_d = drain_q - 2'd1;
        end
      end
      StHalted: begin
        o_pc_stall    = 1'b1;
        o_if_id_flush = 1'b1;
        o_id_ex_flush = 1'b1;
      end
      default: begin
        state_d = StRun;
        drain_d = 2'd0;
      end
    endcase
    if (i_rst) begin
      o_pc_stall    = 1'b0;
      o_if_id_stall = 1'b0;
      o_if_id_flush = 1'b1;
      o_id_ex_flush = 1'b1;
    end
  end

  // FSM state and drain counter.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= StRun;
      drain_q <= 2'd0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
    end
  end

  // Saturating bubble counter; only RUN-state bubbles are counted.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      stall_cnt_q <= 32'd0;
    end else if ((state_q == StRun) && o_id_ex_flush && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign o_halted    = (state_q == StHalted);
  assign o_stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: vector table, randomized run against a
// rule-level reference model, and directed halt/reset/saturation sequences.
module tb_hazard_ctrl;

`ifdef HAZARD_FORWARD_EN
  localparam bit Fwd = 1'b1;
`else
  localparam bit Fwd = 1'b0;
`endif

  logic        clk, rst;
  logic [4:0]  rs1, rs2, exrd, memrd;
  logic        u1, u2, exwe, exmr, memwe, redir, halt;
  logic        pc_stall, ifid_stall, ifid_flush, idex_flush, halted;
  logic [31:0] cnt;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_cnt = 32'd0;
  logic [31:0] saved_cnt;

  typedef struct {
    string      name;
    logic [4:0] rs1, rs2, exrd, memrd;
    logic       u1, u2, exwe, exmr, memwe, redir;
    logic [3:0] efwd, enof;  // {pc_stall, if_id_stall, if_id_flush, id_ex_flush}
  } vec_t;

  vec_t tbl[$];

  hazard_ctrl dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_id_rs1_addr   (rs1),
    .i_id_rs2_addr   (rs2),
    .i_id_uses_rs1   (u1),
    .i_id_uses_rs2   (u2),
    .i_ex_rd_addr    (exrd),
    .i_ex_reg_write  (exwe),
    .i_ex_mem_read   (exmr),
    .i_mem_rd_addr   (memrd),
    .i_mem_reg_write (memwe),
    .i_ex_redirect   (redir),
    .i_ex_retire_halt(halt),
    .o_pc_stall      (pc_stall),
    .o_if_id_stall   (ifid_stall),
    .o_if_id_flush   (ifid_flush),
    .o_id_ex_flush   (idex_flush),
    .o_halted        (halted),
    .o_stall_cnt     (cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add_vec(input string name, input logic [4:0] r1, input logic [4:0] r2,
                         input logic a1, input logic a2, input logic [4:0] erd,
                         input logic ewe, input logic emr, input logic [4:0] mrd,
                         input logic mwe, input logic rdr, input logic [3:0] ef,
                         input logic [3:0] en);
    vec_t v;
    v.name = name; v.rs1 = r1; v.rs2 = r2; v.u1 = a1; v.u2 = a2; v.exrd = erd;
    v.exwe = ewe; v.exmr = emr; v.memrd = mrd; v.memwe = mwe; v.redir = rdr;
    v.efwd = ef; v.enof = en;
    tbl.push_back(v);
  endtask

  task automatic set_in(input logic [4:0] r1, input logic [4:0] r2, input logic a1,
                        input logic a2, input logic [4:0] erd, input logic ewe,
                        input logic emr, input logic [4:0] mrd, input logic mwe,
                        input logic rdr, input logic hlt);
    rs1 = r1; rs2 = r2; u1 = a1; u2 = a2; exrd = erd; exwe = ewe; exmr = emr;
    memrd = mrd; memwe = mwe; redir = rdr; halt = hlt;
  endtask

  // Reference model of the RUN-state rules.
  function automatic logic [3:0] model(input logic [4:0] r1, input logic [4:0] r2,
                                       input logic a1, input logic a2, input logic [4:0] erd,
                                       input logic ewe, input logic emr, input logic [4:0] mrd,
                                       input logic mwe, input logic rdr);
    logic uses_ex, uses_mem, stall;
    uses_ex  = (a1 && r1 == erd) || (a2 && r2 == erd);
    uses_mem = (a1 && r1 == mrd) || (a2 && r2 == mrd);
    stall = (emr && erd != 0 && uses_ex);
    if (!Fwd) stall = stall || (ewe && erd != 0 && uses_ex) || (mwe && mrd != 0 && uses_mem);
    if (rdr) return 4'b0011;
    return stall ? 4'b1101 : 4'b0000;
  endfunction

  function automatic logic [31:0] outs();
    return {28'd0, pc_stall, ifid_stall, ifid_flush, idex_flush};
  endfunction

  // Clock edge in RUN; counter model bumps when a bubble was issued.
  task automatic run_edge(input string name, input logic bubble);
    @(posedge clk);
    #1;
    if (bubble && exp_cnt != 32'hFFFF_FFFF) exp_cnt = exp_cnt + 32'd1;
    chk({name, "_cnt"}, cnt, exp_cnt);
  endtask

  initial begin
    logic [3:0] e;
    rst = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    add_vec("lw_use_rs1", 5, 1, 1, 1, 5, 1, 1, 0, 0, 0, 4'b1101, 4'b1101);
    add_vec("lw_x0",      0, 0, 1, 1, 0, 1, 1, 0, 0, 0, 4'b0000, 4'b0000);
    add_vec("redir_lu",   5, 1, 1, 1, 5, 1, 1, 0, 0, 1, 4'b0011, 4'b0011);
    add_vec("ex_alu_x7",  7, 2, 1, 1, 7, 1, 0, 0, 0, 0, 4'b0000, 4'b1101);
    add_vec("mem_x7",     3, 7, 1, 1, 1, 1, 0, 7, 1, 0, 4'b0000, 4'b1101);
    add_vec("wb_x7",      7, 3, 1, 1, 1, 1, 0, 2, 1, 0, 4'b0000, 4'b0000);
    add_vec("unused_src", 5, 0, 0, 0, 5, 1, 1, 5, 1, 0, 4'b0000, 4'b0000);
    add_vec("lw_use_rs2", 4, 9, 0, 1, 9, 1, 1, 0, 0, 0, 4'b1101, 4'b1101);
    add_vec("redir_only", 1, 2, 1, 1, 3, 1, 0, 4, 1, 1, 4'b0011, 4'b0011);
    add_vec("mem_x0",     0, 0, 1, 1, 6, 1, 0, 0, 1, 0, 4'b0000, 4'b0000);

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_outs", outs(), 32'h3);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_cnt", cnt, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Vector table
    foreach (tbl[i]) begin
      @(negedge clk);
      set_in(tbl[i].rs1, tbl[i].rs2, tbl[i].u1, tbl[i].u2, tbl[i].exrd, tbl[i].exwe,
             tbl[i].exmr, tbl[i].memrd, tbl[i].memwe, tbl[i].redir, 1'b0);
      e = Fwd ? tbl[i].efwd : tbl[i].enof;
      #1;
      chk(tbl[i].name, outs(), {28'd0, e});
      run_edge(tbl[i].name, e[0]);
    end

    // Randomized RUN traffic
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      set_in(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
             5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)),
             1'($urandom), ($urandom_range(0, 7) == 0), 1'b0);
      e = model(rs1, rs2, u1, u2, exrd, exwe, exmr, memrd, memwe, redir);
      #1;
      chk("rand_outs", outs(), {28'd0, e});
      run_edge("rand", e[0]);
    end

    // Halt -> DRAIN (3 edges) -> HALTED, then reset pulse
    @(negedge clk);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    #1;
    chk("halt_req", {30'd0, pc_stall, ifid_flush}, 32'h3);
    @(posedge clk);
    #1;
    saved_cnt = cnt;
    @(negedge clk);
    halt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("drain_outs", outs(), 32'hB);
      chk("drain_not_halted", {31'd0, halted}, 32'd0);
      @(posedge clk);
      @(negedge clk);
    end
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("halted", {31'd0, halted}, 32'd1);
      chk("halted_outs", outs(), 32'hB);
      @(negedge clk);
    end
    chk("drain_cnt_held", cnt, saved_cnt);
    rst = 1'b1;
    #1;
    chk("halt_rst_halted", {31'd0, halted}, 32'd0);
    chk("halt_rst_outs", outs(), 32'h3);
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = 32'd0;
    #1;
    chk("post_rst_cnt", cnt, 32'd0);
    chk("post_rst_idle", outs(), 32'h0);
    set_in(5, 1, 1, 1, 5, 1, 1, 0, 0, 0, 0);
    #1;
    chk("post_rst_lu", outs(), 32'hD);
    run_edge("post_rst_lu", 1'b1);

    // Reset in the middle of DRAIN
    @(negedge clk);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    @(posedge clk);
    @(negedge clk);
    halt = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_drain_rst_outs", outs(), 32'h3);
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = 32'd0;
    #1;
    chk("mid_drain_run", outs(), 32'h0);
    repeat (4) @(posedge clk);
    #1;
    chk("mid_drain_no_halt", {31'd0, halted}, 32'd0);

    // Counter saturation
    @(negedge clk);
    force dut.stall_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.stall_cnt_q;
    exp_cnt = 32'hFFFF_FFFE;
    chk("preload", cnt, exp_cnt);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      set_in(5, 1, 1, 1, 5, 1, 1, 0, 0, 0, 0);
      #1;
      chk("sat_lu", outs(), 32'hD);
      run_edge("sat", 1'b1);
    end
    chk("sat_value", cnt, 32'hFFFF_FFFF);
    @(negedge clk);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    run_edge("sat_idle", 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
